// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative 32-bit multiply/divide unit with HI/LO registers.
//
// An operation accepted in IDLE runs 32 iterations in CALC (shift-add for
// multiply, restoring subtract-shift for divide) on magnitudes. FIX then
// applies the sign correction and writes HI/LO, and DONE pulses `done` for
// one cycle. MTHI/MTLO writes are accepted only while the unit is idle or
// in DONE.
//
// Configuration macro: MULDIV_DIV_EN
//   defined   -> DIVU/DIV are computed.
//   undefined -> no divide datapath; a DIVU/DIV request goes straight from
//                IDLE to DONE on the accepting edge, leaves HI/LO untouched
//                and never raises busy.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, op[1:0]       request; op 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   operand_a/operand_b  rs (multiplicand/dividend), rt (multiplier/divisor)
//   hilo_wr, hilo_sel    MTHI/MTLO strobe; sel 1 = HI, 0 = LO (also read sel)
//   hilo_wdata           MTHI/MTLO data
//   busy, done           in progress (CALC/FIX) / one-cycle completion pulse
//   hi_o, lo_o           HI and LO registers
//   hilo_rdata           MFHI/MFLO value (combinational select of HI/LO)
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        hilo_wr,
  input  logic        hilo_sel,
  input  logic [31:0] hilo_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] hilo_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r, state_next_s;
  logic [4:0]  cnt_r;
  logic [31:0] opa_r;         // |multiplicand| or |dividend|
  logic [63:0] acc_r;         // multiply: {partial, multiplier}; divide: {rem, quot}
  logic        neg_lo_r;      // negate product / quotient in FIX
  logic [31:0] hi_r, lo_r;
  logic        busy_r, done_r;
  logic        start_ok_s;
  logic        calc_go_s;
  logic [31:0] a_abs_s, b_abs_s;
  logic [32:0] mul_sum_s;
  logic [63:0] acc_step_s;
  logic [63:0] prod_s;
  logic [31:0] hi_fix_s, lo_fix_s;
`ifdef MULDIV_DIV_EN
  logic        op_div_r;
  logic [31:0] opb_r;         // |divisor|
  logic        neg_hi_r;      // remainder takes the dividend's sign
  logic [32:0] rem_sh_s;
  logic [31:0] rem_diff_s;
`endif

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    if (is_signed && v[31]) abs32 = 32'd0 - v;
    else                    abs32 = v;
  endfunction

  function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
    if (neg) cneg32 = 32'd0 - v;
    else     cneg32 = v;
  endfunction

  function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
    if (neg) cneg64 = 64'd0 - v;
    else     cneg64 = v;
  endfunction

  assign start_ok_s = (state_r == IDLE) && start;
  assign a_abs_s    = abs32(operand_a, op[0]);
  assign b_abs_s    = abs32(operand_b, op[0]);
`ifdef MULDIV_DIV_EN
  assign calc_go_s  = start_ok_s;
`else
  assign calc_go_s  = start_ok_s && !op[1];
`endif

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (calc_go_s)       state_next_s = CALC;
        else if (start_ok_s) state_next_s = DONE;   // divide request with no divider
        else                 state_next_s = IDLE;
      end
      CALC: begin
        if (cnt_r == 5'd31) state_next_s = FIX;
        else                state_next_s = CALC;
      end
      FIX:     state_next_s = DONE;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_next_s;
  end

  // Registered status outputs, decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == CALC) || (state_next_s == FIX);
      done_r <= (state_next_s == DONE);
    end
  end

  // One iteration of the shift-add multiplier or restoring divider
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opa_r} : 33'd0);
    acc_step_s = {mul_sum_s, acc_r[31:1]};
`ifdef MULDIV_DIV_EN
    rem_sh_s   = {acc_r[63:32], acc_r[31]};
    // Remainder stays below the divisor, so the true difference fits 32 bits.
    rem_diff_s = rem_sh_s[31:0] - opb_r;
    if (op_div_r) begin
      if (rem_sh_s >= {1'b0, opb_r}) acc_step_s = {rem_diff_s, acc_r[30:0], 1'b1};
      else                           acc_step_s = {rem_sh_s[31:0], acc_r[30:0], 1'b0};
    end else begin
      acc_step_s = {mul_sum_s, acc_r[31:1]};
    end
`endif
  end

  // Sign-corrected results written to HI/LO in FIX
  always_comb begin
    prod_s   = cneg64(acc_r, neg_lo_r);
    hi_fix_s = prod_s[63:32];
    lo_fix_s = prod_s[31:0];
`ifdef MULDIV_DIV_EN
    if (op_div_r) begin
      if (opb_r == 32'd0) begin
        // Re-signing the magnitude restores the raw dividend, 0x80000000 included.
        hi_fix_s = cneg32(opa_r, neg_hi_r);
        lo_fix_s = 32'hFFFF_FFFF;
      end else begin
        hi_fix_s = cneg32(acc_r[63:32], neg_hi_r);
        lo_fix_s = cneg32(acc_r[31:0], neg_lo_r);
      end
    end else begin
      hi_fix_s = prod_s[63:32];
      lo_fix_s = prod_s[31:0];
    end
`endif
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= 5'd0;
      opa_r    <= 32'd0;
      acc_r    <= 64'd0;
      neg_lo_r <= 1'b0;
`ifdef MULDIV_DIV_EN
      op_div_r <= 1'b0;
      opb_r    <= 32'd0;
      neg_hi_r <= 1'b0;
`endif
    end else if (calc_go_s) begin
      cnt_r    <= 5'd0;
      opa_r    <= a_abs_s;
      neg_lo_r <= op[0] & (operand_a[31] ^ operand_b[31]);
`ifdef MULDIV_DIV_EN
      op_div_r <= op[1];
      opb_r    <= b_abs_s;
      neg_hi_r <= op[0] & operand_a[31];
      acc_r    <= op[1] ? {32'd0, a_abs_s} : {32'd0, b_abs_s};
`else
      acc_r    <= {32'd0, b_abs_s};
`endif
    end else if (state_r == CALC) begin
      cnt_r <= cnt_r + 5'd1;   // wraps 31 -> 0 as CALC hands over to FIX
      acc_r <= acc_step_s;
    end
  end

  // HI/LO registers: result write in FIX, MTHI/MTLO only in IDLE or DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (state_r == FIX) begin
      hi_r <= hi_fix_s;
      lo_r <= lo_fix_s;
    end else if (hilo_wr && ((state_r == IDLE) || (state_r == DONE))) begin
      if (hilo_sel) hi_r <= hilo_wdata;
      else          lo_r <= hilo_wdata;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign hi_o       = hi_r;
  assign lo_o       = lo_r;
  assign hilo_rdata = hilo_sel ? hi_r : lo_r;

endmodule
